// File: rtl/nou_aw_pkg.sv
// Shared types and constants for the NOU AXI write-address path.
// Used by the AW burst master and its burst length helper.
package nou_aw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    FIN
  } aw_state_e;

  localparam logic [1:0] AWSEL_NONE = 2'd0;
  localparam logic [1:0] AWSEL_HDR  = 2'd1;
  localparam logic [1:0] AWSEL_DATA = 2'd2;

  localparam int AXI_4K_BYTES = 4096;

endpackage

// File: rtl/axi_aw_burst_master_if.sv
// AXI write-address channel bundle with the phase select
// that steers flit data on the W path.
interface axi_aw_burst_master_if #(
  parameter int ADDR_W = 32
);

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [1:0]        awsel;

  modport master (
    output awvalid,
    output awaddr,
    output awlen,
    output awsel,
    input  awready
  );

  modport slave (
    input  awvalid,
    input  awaddr,
    input  awlen,
    input  awsel,
    output awready
  );

endinterface

// File: rtl/aw_burst_len_calc.sv
// Beats for the next AW command: bounded by remaining flits,
// the burst cap and the distance to the next 4 KB boundary.
module aw_burst_len_calc
  import nou_aw_pkg::*;
#(
  parameter int RW         = 13,
  parameter int BEAT_BYTES = 16,
  parameter int MAX_BURST  = 16,
  parameter bit BURST_EN   = 1'b1
) (
  input  logic [RW-1:0] rem,
  input  logic [11:0]   addr_lo,
  output logic [8:0]    beats
);

  localparam int SH = $clog2(BEAT_BYTES);

  logic [31:0] r;
  logic [31:0] room;
  logic [31:0] m;

  always_comb begin
    r    = 32'(rem);
    room = (32'(AXI_4K_BYTES) - 32'(addr_lo)) >> SH;
    m    = r;
    if (m > 32'(MAX_BURST)) m = 32'(MAX_BURST);
    if (m > room) m = room;
    beats = BURST_EN ? 9'(m) : 9'd1;
  end

endmodule

// File: rtl/axi_aw_burst_master.sv
// AW command generator: header region then data region per packet,
// optionally merged into 4 KB-safe INCR bursts.
module axi_aw_burst_master
  import nou_aw_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int HDR_W      = 6,
  parameter int DATA_W     = 12,
  parameter int BEAT_BYTES = 16,
  parameter int MAX_BURST  = 16,
  parameter bit BURST_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     pkt_addr,
  input  logic [HDR_W-1:0]      hdr_flit_num,
  input  logic [DATA_W-1:0]     data_flit_num,
  axi_aw_burst_master_if.master aw,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (HDR_W > DATA_W ? HDR_W : DATA_W) + 1;
  localparam int SH = $clog2(BEAT_BYTES);
  localparam logic [ADDR_W-1:0] AMASK = {ADDR_W{1'b1}} << SH;

  aw_state_e         state, nxt_state;
  logic [CW-1:0]     rem, nxt_rem, left;
  logic [ADDR_W-1:0] cur_addr, nxt_addr;
  logic [ADDR_W-1:0] pkt_q, nxt_pkt;
  logic [DATA_W-1:0] data_q, nxt_data;
  logic [8:0]        used, beats;
  logic              hs, nxt_vld;

  always_comb begin
    nxt_state = state;
    nxt_rem   = rem;
    nxt_addr  = cur_addr;
    nxt_pkt   = pkt_q;
    nxt_data  = data_q;
    hs        = aw.awvalid & aw.awready;
    used      = {1'b0, aw.awlen} + 9'd1;
    left      = rem - CW'(used);
    unique case (state)
      IDLE: begin
        if (start) begin
          nxt_pkt  = pkt_addr & AMASK;
          nxt_data = data_flit_num;
          nxt_rem  = CW'(hdr_flit_num);
          nxt_addr = base_addr & AMASK;
          if (hdr_flit_num != '0) begin
            nxt_state = HDR;
          end else if (data_flit_num != '0) begin
            nxt_state = DATA;
            nxt_rem   = CW'(data_flit_num);
            nxt_addr  = pkt_addr & AMASK;
          end else begin
            nxt_state = FIN;
          end
        end
      end
      HDR, DATA: begin
        if (hs) begin
          if (left != '0) begin
            nxt_rem  = left;
            nxt_addr = cur_addr + (ADDR_W'(used) << SH);
          end else if (state == HDR && data_q != '0) begin
            nxt_state = DATA;
            nxt_rem   = CW'(data_q);
            nxt_addr  = pkt_q;
          end else begin
            nxt_state = FIN;
          end
        end
      end
      FIN:     nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
    nxt_vld = (nxt_state == HDR) || (nxt_state == DATA);
  end

  // Sized from next-cycle values so the command is a plain flop.
  aw_burst_len_calc #(
    .RW        (CW),
    .BEAT_BYTES(BEAT_BYTES),
    .MAX_BURST (MAX_BURST),
    .BURST_EN  (BURST_EN)
  ) u_len (
    .rem    (nxt_rem),
    .addr_lo(nxt_addr[11:0]),
    .beats  (beats)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      cur_addr   <= '0;
      pkt_q      <= '0;
      data_q     <= '0;
      aw.awvalid <= 1'b0;
      aw.awaddr  <= '0;
      aw.awlen   <= '0;
      aw.awsel   <= AWSEL_NONE;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= nxt_state;
      rem        <= nxt_rem;
      cur_addr   <= nxt_addr;
      pkt_q      <= nxt_pkt;
      data_q     <= nxt_data;
      aw.awvalid <= nxt_vld;
      aw.awaddr  <= nxt_vld ? nxt_addr : '0;
      aw.awlen   <= nxt_vld ? 8'(beats - 9'd1) : '0;
      aw.awsel   <= (nxt_state == HDR)  ? AWSEL_HDR  :
                    (nxt_state == DATA) ? AWSEL_DATA :
                                          AWSEL_NONE;
      busy       <= nxt_state != IDLE;
      done       <= state == FIN;
    end
  end

endmodule

// File: tb/tb_axi_aw_burst_master.sv
// Bench for axi_aw_burst_master: burst and single-beat instances
// side by side against a command-list model.
module tb_axi_aw_burst_master;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  sel;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        awready = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] pkt_addr = '0;
  logic [5:0]  hdr = '0;
  logic [11:0] data = '0;
  logic        busy_b, done_b, busy_s, done_s;

  axi_aw_burst_master_if #(.ADDR_W(32)) aw_b ();
  axi_aw_burst_master_if #(.ADDR_W(32)) aw_s ();

  assign aw_b.awready = awready;
  assign aw_s.awready = awready;

  axi_aw_burst_master #(
    .ADDR_W(32), .HDR_W(6), .DATA_W(12),
    .BEAT_BYTES(16), .MAX_BURST(16), .BURST_EN(1'b1)
  ) u_b (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .pkt_addr(pkt_addr),
    .hdr_flit_num(hdr), .data_flit_num(data),
    .aw(aw_b), .busy(busy_b), .done(done_b)
  );

  axi_aw_burst_master #(
    .ADDR_W(32), .HDR_W(6), .DATA_W(12),
    .BEAT_BYTES(16), .MAX_BURST(16), .BURST_EN(1'b0)
  ) u_s (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .pkt_addr(pkt_addr),
    .hdr_flit_num(hdr), .data_flit_num(data),
    .aw(aw_s), .busy(busy_s), .done(done_s)
  );

  always #5 clk = ~clk;

  logic ov[2];
  logic ob[2];
  logic od[2];
  cmd_t oc[2];

  assign ov[0] = aw_b.awvalid;
  assign ov[1] = aw_s.awvalid;
  assign ob[0] = busy_b;
  assign ob[1] = busy_s;
  assign od[0] = done_b;
  assign od[1] = done_s;
  assign oc[0] = {aw_b.awaddr, aw_b.awlen, aw_b.awsel};
  assign oc[1] = {aw_s.awaddr, aw_s.awlen, aw_s.awsel};

  cmd_t eq[2][128];
  cmd_t lg[2][128];
  int   hd[2], tl[2], lgn[2];
  bit   mbusy[2], finf[2], edone[2];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Expected command list for one packet, straight from the sizing rule.
  task automatic build(input int k);
    int n, b, room;
    logic [31:0] a;
    tl[k]  = 0;
    hd[k]  = 0;
    lgn[k] = 0;
    for (int r = 0; r < 2; r++) begin
      n = (r == 0) ? int'(hdr) : int'(data);
      a = ((r == 0) ? base_addr : pkt_addr) & 32'hFFFF_FFF0;
      while (n > 0) begin
        b = 1;
        if (k == 0) begin
          room = (4096 - int'(a[11:0])) / 16;
          b = (n < 16) ? n : 16;
          if (room < b) b = room;
        end
        if (tl[k] < 128) begin
          eq[k][tl[k]] = {a, 8'(b - 1), 2'(r + 1)};
          tl[k]++;
        end
        a = a + 32'(b * 16);
        n -= b;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ov[k] && awready && lgn[k] < 128) begin
        lg[k][lgn[k]] = oc[k];
        lgn[k]++;
      end
      if (rst) begin
        hd[k] = 0; tl[k] = 0;
        mbusy[k] = 1'b0; finf[k] = 1'b0; edone[k] = 1'b0;
      end else begin
        edone[k] = 1'b0;
        if (finf[k]) begin
          finf[k] = 1'b0; edone[k] = 1'b1; mbusy[k] = 1'b0;
        end else if (!mbusy[k]) begin
          if (start) begin
            build(k);
            mbusy[k] = 1'b1;
            if (hd[k] == tl[k]) finf[k] = 1'b1;
          end
        end else if (hd[k] < tl[k] && awready) begin
          hd[k]++;
          if (hd[k] == tl[k]) finf[k] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk(k ? "s_awvalid" : "b_awvalid", ov[k], hd[k] < tl[k]);
        if (hd[k] < tl[k] && hd[k] < 128)
          chk(k ? "s_cmd" : "b_cmd", oc[k], eq[k][hd[k]]);
        chk(k ? "s_busy" : "b_busy", ob[k], mbusy[k]);
        chk(k ? "s_done" : "b_done", od[k], edone[k]);
      end
    end
  end

  task automatic send(input logic [31:0] b, input logic [31:0] p,
                      input int h, input int d);
    @(negedge clk);
    base_addr = b;
    pkt_addr  = p;
    hdr       = 6'(h);
    data      = 12'(d);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((mbusy[0] || mbusy[1]) && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("idle_timeout", c < 500, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    chk_on = 1'b1;
    chk("rst_awvalid", aw_b.awvalid, 0);
    chk("rst_cmd", oc[0], 0);
    chk("rst_busy", busy_b, 0);
    chk("rst_done", done_s, 0);
    @(negedge clk);
    rst = 1'b0;

    awready = 1'b1;
    send(32'h1000, 32'h2000, 1, 4);
    wait_idle();
    chk("basic_n", lgn[0], 2);
    chk("basic_0", lg[0][0], {32'h1000, 8'd0, 2'd1});
    chk("basic_1", lg[0][1], {32'h2000, 8'd3, 2'd2});
    chk("basic_sn", lgn[1], 5);

    send(32'h0, 32'h2FC0, 0, 8);
    wait_idle();
    chk("split4k_n", lgn[0], 2);
    chk("split4k_0", lg[0][0], {32'h2FC0, 8'd3, 2'd2});
    chk("split4k_1", lg[0][1], {32'h3000, 8'd3, 2'd2});

    send(32'h0, 32'h4000, 0, 40);
    wait_idle();
    chk("maxb_n", lgn[0], 3);
    chk("maxb_0", lg[0][0], {32'h4000, 8'd15, 2'd2});
    chk("maxb_1", lg[0][1], {32'h4100, 8'd15, 2'd2});
    chk("maxb_2", lg[0][2], {32'h4200, 8'd7, 2'd2});

    send(32'h1000, 32'h0, 3, 0);
    wait_idle();
    chk("single_n", lgn[1], 3);
    chk("single_0", lg[1][0], {32'h1000, 8'd0, 2'd1});
    chk("single_1", lg[1][1], {32'h1010, 8'd0, 2'd1});
    chk("single_2", lg[1][2], {32'h1020, 8'd0, 2'd1});
    chk("single_b", lg[0][0], {32'h1000, 8'd2, 2'd1});

    send(32'h1007, 32'h200F, 1, 1);
    wait_idle();
    chk("align_0", lg[0][0], {32'h1000, 8'd0, 2'd1});
    chk("align_1", lg[0][1], {32'h2000, 8'd0, 2'd2});

    awready = 1'b0;
    send(32'h1100, 32'h2200, 2, 3);
    @(negedge clk);
    base_addr = 32'h9000;
    hdr       = 6'd7;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("bp_valid", aw_b.awvalid, 1);
    chk("bp_cmd", oc[0], {32'h1100, 8'd1, 2'd1});
    @(negedge clk);
    awready = 1'b1;
    wait_idle();
    chk("bp_n", lgn[0], 2);
    chk("bp_0", lg[0][0], {32'h1100, 8'd1, 2'd1});
    chk("bp_1", lg[0][1], {32'h2200, 8'd2, 2'd2});

    send(32'h0, 32'h0, 0, 0);
    chk("zero_busy", busy_b, 1);
    chk("zero_done0", done_b, 0);
    @(negedge clk);
    chk("zero_done1", done_b, 1);
    chk("zero_valid", aw_b.awvalid, 0);
    wait_idle();
    chk("zero_n", lgn[0], 0);

    send(32'h0, 32'h4000, 0, 40);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_valid", aw_b.awvalid, 0);
    chk("mrst_cmd", oc[0], 0);
    chk("mrst_svalid", aw_s.awvalid, 0);
    chk("mrst_busy", busy_s, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mrst_nodone", done_b | done_s, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_aw_burst_master.md
Name: axi_aw_burst_master

Overview:
- Next-generation AW-channel command generator for the NOU AXI master path.
- Per packet, issues write-address commands for a header region (at base_addr) and then a data region (at pkt_addr).
- Parametrised in address width, beat size and maximum burst length.
- Optionally merges consecutive flits into INCR bursts that never cross a 4 KB boundary, instead of one single-beat command per flit.
- Sits between the packet decoder (which supplies addresses and flit counts) and the AXI AW port; the W-path uses awsel/awlen to steer flit data.

Parameters:
ADDR_W, 32, AW address width
HDR_W, 6, width of header flit count
DATA_W, 12, width of data flit count
BEAT_BYTES, 16, bytes per flit/beat (power of two, at most 4096)
MAX_BURST, 16, maximum beats per command (1..256)
BURST_EN, 1, 1 = merge beats into bursts; 0 = one single-beat command per flit (awlen always 0)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  packet start pulse; accepted only in IDLE, ignored otherwise
base_addr  in  ADDR_W  header region start, sampled on accepted start
pkt_addr  in  ADDR_W  data region start, sampled on accepted start
hdr_flit_num  in  HDR_W  header beats, sampled on start; 0 skips the header phase
data_flit_num  in  DATA_W  data beats, sampled on start; 0 skips the data phase
awready  in  1  AXI slave ready
awvalid  out  1  AXI command valid
awaddr  out  ADDR_W  command address
awlen  out  8  beats minus 1
awsel  out  2  phase of the current command: 0 none, 1 header, 2 data
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last handshake, or after start if both counts are 0

Behaviour:
- Reset: synchronous and active-high. All outputs are 0 in the cycle after rst is sampled high, and the state is IDLE.
- Reset mid-operation: abandons the packet; awvalid drops and no done pulse is generated.
- Registered outputs: awvalid, awaddr, awlen and awsel are flops, not combinational paths from inputs.
- Address alignment: the low log2(BEAT_BYTES) bits of both sampled addresses are forced to 0.

State machine: IDLE, HDR, DATA, FIN.
- IDLE, start=1: latch addresses and counts, rem := hdr_flit_num.
  - hdr>0: go to HDR; awvalid=1 in the next cycle (latency 1).
  - hdr=0, data>0: go to DATA.
  - both 0: go to FIN.
- HDR: commands issued at cur_addr, starting at base_addr.
  - On handshake (awvalid&awready): rem -= awlen+1 and cur_addr += (awlen+1)*BEAT_BYTES.
  - If rem reaches 0: rem := data count, cur_addr := pkt_addr, go to DATA (or FIN if data=0).
- DATA: same rules; when rem reaches 0, go to FIN.
- FIN: assert done for one cycle, go to IDLE.

Handshake and burst sizing:
- Back-to-back commands: the next command is loaded in the handshake cycle, so awvalid stays high with no bubble.
- While awvalid=1 and awready=0, awaddr/awlen/awsel hold stable and awvalid holds high.
- Burst length, when BURST_EN=1: beats = min(rem, MAX_BURST, (4096 - cur_addr[11:0]) / BEAT_BYTES), and awlen = beats-1.
- When BURST_EN=0: beats = 1.
- Burst-length arithmetic is done at DATA_W+1 bits to avoid truncation.
- Address arithmetic wraps modulo 2^ADDR_W with no error flag.
- start asserted while busy is ignored and has no effect on the current packet.

Decomposition:
- Shared package nou_aw_pkg:
  - state enum aw_state_e {IDLE, HDR, DATA, FIN}
  - awsel constants AWSEL_NONE/HDR/DATA
  - constant AXI_4K_BYTES=4096
- One sub-module, aw_burst_len_calc (combinational): computes beats from rem, cur_addr, MAX_BURST and BEAT_BYTES.

Test Plan (BEAT_BYTES=16, MAX_BURST=16 unless noted):
- Basic packet: hdr=1, data=4, base 0x1000, pkt 0x2000, awready=1.
  -> AW (0x1000, len 0, sel 1), then (0x2000, len 3, sel 2); done one cycle after the second handshake.
- 4 KB split: hdr=0, data=8, pkt 0x2FC0.
  -> (0x2FC0, len 3), then (0x3000, len 3).
- MAX_BURST split: data=40, pkt 0x4000.
  -> (0x4000, len 15), (0x4100, len 15), (0x4200, len 7); awvalid continuous across all three.
- BURST_EN=0: hdr=3, base 0x1000, data=0.
  -> (0x1000, 0x1010, 0x1020), each len 0, then done.
- Backpressure: awready held 0 for 5 cycles on the first command.
  -> awaddr/awlen/awsel stable and awvalid=1 throughout; start pulses during busy are ignored.
- Edge cases:
  - hdr=0, data=0 -> done in the cycle after FIN is entered, awvalid never asserted.
  - rst=1 in the middle of DATA -> all outputs 0 in the next cycle, no done pulse.
